// File: rtl/unit_a_sequencer_pkg.sv
// unit_a_sequencer_pkg: shared function codes, state encoding and data width
package unit_a_sequencer_pkg;
  localparam int DW = 32;
  localparam logic [3:0] F_SUM  = 4'b0100;
  localparam logic [3:0] F_SUB  = 4'b0101;
  localparam logic [3:0] F_AINV = 4'b0110;
  localparam logic [3:0] F_INC  = 4'b0111;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/unit_a_sequencer_unit_a.sv
// unit_a_sequencer_unit_a: combinational unit_A datapath (sum/sub/ainv/inc with carry and signed overflow)
module unit_a_sequencer_unit_a
  import unit_a_sequencer_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    f,
  output logic [DW-1:0] s,
  output logic          c_out,
  output logic          o
);
  logic [DW-1:0] bb;
  logic [DW:0]   r;
  // sub is a + ~b + 1 so c_out means "no borrow"; inc is a + 0 + 1
  always_comb begin
    bb    = f == F_SUB ? ~b : f == F_INC ? '0 : b;
    r     = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, f == F_SUB || f == F_INC};
    s     = f == F_AINV ? ~a : r[DW-1:0];
    c_out = f == F_AINV ? 1'b0 : r[DW];
    o     = f != F_AINV && a[DW-1] == bb[DW-1] && s[DW-1] != a[DW-1];
  end
endmodule

// File: rtl/unit_a_sequencer.sv
// unit_a_sequencer: valid/ready command issuer around unit_A with accumulator and sticky overflow
module unit_a_sequencer
  import unit_a_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_f,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic          cmd_acc,
  input  logic          clr_ovf,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_s,
  output logic          rsp_c,
  output logic          rsp_o,
  output logic          rsp_z,
  output logic          rsp_n,
  output logic          rsp_err,
  output logic [DW-1:0] acc,
  output logic          ovf_sticky
);
  state_t        state;
  logic [3:0]    cnt;
  logic [DW-1:0] ra, rb, s;
  logic [3:0]    rf;
  logic          c_out, o, legal;

  assign legal = rf[3:2] == 2'b01;

  unit_a_sequencer_unit_a u_unit_a (.a(ra), .b(rb), .f(rf), .s(s), .c_out(c_out), .o(o));

  // EXEC spends one launch cycle plus SETTLE_CYCLES of stable inputs before capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ra         <= '0;
      rb         <= '0;
      rf         <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_s      <= '0;
      rsp_c      <= 1'b0;
      rsp_o      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_n      <= 1'b0;
      rsp_err    <= 1'b0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (clr_ovf) ovf_sticky <= 1'b0;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          ra        <= cmd_acc ? acc : cmd_a;
          rb        <= cmd_b;
          rf        <= cmd_f;
          cnt       <= '0;
          cmd_ready <= 1'b0;
          state     <= ST_EXEC;
        end
        ST_EXEC: if (cnt == 4'(SETTLE_CYCLES)) begin
          rsp_s     <= legal ? s : '0;
          rsp_c     <= legal & c_out;
          rsp_o     <= legal & o;
          rsp_z     <= !legal || s == '0;
          rsp_n     <= legal & s[DW-1];
          rsp_err   <= !legal;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
          if (legal) acc <= s;
          if (legal && o) ovf_sticky <= 1'b1;
        end else cnt <= cnt + 4'd1;
        ST_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_unit_a_sequencer.sv
// tb_unit_a_sequencer: directed stimulus with a response scoreboard checked by a separate monitor
module tb_unit_a_sequencer;
  typedef struct packed {
    logic [31:0] s;
    logic        c, o, z, n, err;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_acc = 1'b0, clr_ovf = 1'b0;
  logic [3:0]  cmd_f = 4'b0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_s, acc;
  logic        rsp_c, rsp_o, rsp_z, rsp_n, rsp_err, ovf_sticky;

  int checks = 0, failures = 0;
  exp_t q[$];

  unit_a_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_f(cmd_f),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc), .clr_ovf(clr_ovf), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_c(rsp_c), .rsp_o(rsp_o), .rsp_z(rsp_z),
    .rsp_n(rsp_n), .rsp_err(rsp_err), .acc(acc), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, o, z, n, err, input logic [31:0] a);
    return '{s: s, c: c, o: o, z: z, n: n, err: err, acc: a};
  endfunction

  // monitor: every accepted response is matched against the oldest expectation
  always @(negedge clk)
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("unexpected_rsp", 72'(1), 72'(0));
      else chk("rsp", 72'({rsp_s, rsp_c, rsp_o, rsp_z, rsp_n, rsp_err, acc}), 72'(q.pop_front()));
    end

  task automatic send(input logic [3:0] f, input logic [31:0] a, b, input logic ac, input exp_t e);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 72'(0), 72'(1));
    cmd_valid = 1'b1; cmd_f = f; cmd_a = a; cmd_b = b; cmd_acc = ac;
    q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = 32'hDEADBEEF; cmd_b = 32'h12345678; cmd_f = 4'b0100; cmd_acc = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("latency", 72'(k), 72'(2));
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [71:0] snap;
    logic seen;
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1);
  end

  initial begin
    logic [71:0] snap;
    logic        seen;
    #12;
    chk("reset_state", 72'({cmd_ready, rsp_valid, rsp_s, rsp_c, rsp_o, rsp_z, rsp_n, rsp_err, acc, ovf_sticky}),
        72'({1'b1, 1'b0, 32'h0, 5'b0, 32'h0, 1'b0}));
    @(negedge clk); rst_n = 1'b1;
    send(4'b0100, 32'd6, 32'd6, 1'b0, mk(32'hC, 0, 0, 0, 0, 0, 32'hC));
    send(4'b0101, 32'd6, 32'd6, 1'b0, mk(32'h0, 1, 0, 1, 0, 0, 32'h0));
    send(4'b0100, 32'h7FFFFFFF, 32'd1, 1'b0, mk(32'h80000000, 0, 1, 0, 1, 0, 32'h80000000));
    chk("ovf_set", 72'(ovf_sticky), 72'(1));
    @(negedge clk); clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    chk("ovf_clear", 72'(ovf_sticky), 72'(0));
    send(4'b0101, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, mk(32'h80000000, 0, 1, 0, 1, 0, 32'h80000000));
    send(4'b0101, 32'h7FFFFFFF, 32'd1, 1'b0, mk(32'h7FFFFFFE, 1, 0, 0, 0, 0, 32'h7FFFFFFE));
    chk("ovf_sticky_held", 72'(ovf_sticky), 72'(1));
    send(4'b0111, 32'd0, 32'd0, 1'b0, mk(32'h1, 0, 0, 0, 0, 0, 32'h1));
    send(4'b0111, 32'h55555555, 32'd0, 1'b1, mk(32'h2, 0, 0, 0, 0, 0, 32'h2));
    send(4'b0111, 32'h55555555, 32'd0, 1'b1, mk(32'h3, 0, 0, 0, 0, 0, 32'h3));
    rsp_ready = 1'b0;
    send(4'b0111, 32'h55555555, 32'd0, 1'b1, mk(32'h4, 0, 0, 0, 0, 0, 32'h4));
    snap = {rsp_s, rsp_c, rsp_o, rsp_z, rsp_n, rsp_err, acc};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold", 72'({rsp_valid, cmd_ready, rsp_s, rsp_c, rsp_o, rsp_z, rsp_n, rsp_err}),
          72'({1'b1, 1'b0, snap[68:32]}));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    send(4'b0110, 32'h0F0F0F0F, 32'd0, 1'b0, mk(32'hF0F0F0F0, 0, 0, 0, 1, 0, 32'hF0F0F0F0));
    send(4'b1010, 32'd5, 32'd5, 1'b0, mk(32'h0, 0, 0, 1, 0, 1, 32'hF0F0F0F0));
    chk("ovf_after_illegal", 72'(ovf_sticky), 72'(1));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_f = 4'b0100; cmd_a = 32'd1; cmd_b = 32'd1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_exec", 72'({cmd_ready, rsp_valid, rsp_s, rsp_c, rsp_o, rsp_z, rsp_n, rsp_err, acc, ovf_sticky}),
        72'({1'b1, 1'b0, 32'h0, 5'b0, 32'h0, 1'b0}));
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1 seen |= rsp_valid; end
    chk("no_rsp_after_reset", 72'({seen, acc}), 72'({1'b0, 32'h0}));
    chk("scoreboard_empty", 72'(q.size()), 72'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
